fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_ifid.sv | 41 ++++
 rtl/fetch_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

    localparam logic [1:0]  PC_SEQ = 2'b00;
    localparam logic [1:0]  PC_BR  = 2'b01;
    localparam logic [1:0]  PC_J   = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // pc_src 2'b11 is deliberately not a redirect; it behaves as sequential.
    function automatic logic is_redirect(input logic [1:0] src);
        return (src == PC_BR) || (src == PC_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_ifid.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register with synchronous clear and hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_inst;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Clear wins over load so a redirect always leaves a bubble behind it.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_inst  <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : PC generation, instruction memory handshake and IF/ID feed.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_src,
    input  logic [31:0]      branch_target,
    input  logic [25:0]      jump_addr,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ifid_inst,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [31:0]      fetched_cnt,
    output logic [CNT_W-1:0] discard_cnt
);

    fetch_state_t     r_state;
    fetch_state_t     w_next_state;

    logic [31:0]      r_pc;
    logic [31:0]      r_req_addr;
    logic [31:0]      r_buf;
    logic [31:0]      r_buf_pc4;
    logic [31:0]      r_fetched_cnt;
    logic [CNT_W-1:0] r_discard_cnt;

    logic             w_redirect;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_pc_next;
    logic             w_buf_load;
    logic             w_disc_inc;
    logic             w_ifid_load;
    logic             w_ifid_clear;
    logic [31:0]      w_ifid_inst_d;
    logic [31:0]      w_ifid_pc4_d;

    assign w_redirect = is_redirect(pc_src);
    assign w_target   = (pc_src == PC_BR) ? branch_target
                                          : {ifid_pc4[31:28], jump_addr, 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_pc_next     = r_pc;
        w_buf_load    = 1'b0;
        w_disc_inc    = 1'b0;
        w_ifid_load   = 1'b0;
        w_ifid_clear  = 1'b0;
        w_ifid_inst_d = imem_rdata;
        w_ifid_pc4_d  = w_pc_plus4;
        case (r_state)
            ST_FETCH: begin
                if (w_redirect) begin
                    w_ifid_clear = 1'b1;
                    w_pc_next    = w_target;
                    if (imem_ready) begin
                        w_disc_inc = 1'b1;
                    end else begin
                        w_next_state = ST_KILL;
                    end
                end else if (imem_ready) begin
                    w_pc_next = w_pc_plus4;
                    if (!stall) begin
                        w_ifid_load = 1'b1;
                    end else begin
                        w_buf_load   = 1'b1;
                        w_next_state = ST_HOLD;
                    end
                end else if (!stall) begin
                    w_ifid_clear = 1'b1;
                end
            end
            ST_HOLD: begin
                w_ifid_inst_d = r_buf;
                w_ifid_pc4_d  = r_buf_pc4;
                if (w_redirect) begin
                    w_disc_inc   = 1'b1;
                    w_pc_next    = w_target;
                    w_ifid_clear = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (!stall) begin
                    w_ifid_load  = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_KILL: begin
                // The outstanding request still has to drain before refetching.
                if (w_redirect) begin
                    w_pc_next = w_target;
                end
                if (w_redirect || !stall) begin
                    w_ifid_clear = 1'b1;
                end
                if (imem_ready) begin
                    w_disc_inc   = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b1;
        imem_addr = r_pc;
        case (r_state)
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = r_pc;
            end
            ST_HOLD: begin
                imem_req  = 1'b0;
                imem_addr = r_pc;
            end
            ST_KILL: begin
                imem_req  = 1'b1;
                imem_addr = r_req_addr;
            end
            default: begin
                imem_req  = 1'b1;
                imem_addr = r_pc;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_buf         <= 32'h0;
            r_buf_pc4     <= 32'h0;
            r_fetched_cnt <= 32'h0;
            r_discard_cnt <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (r_state == ST_FETCH) begin
                r_req_addr <= r_pc;
            end
            if (w_buf_load) begin
                r_buf     <= imem_rdata;
                r_buf_pc4 <= w_pc_plus4;
            end
            if (w_ifid_load && !w_ifid_clear) begin
                r_fetched_cnt <= r_fetched_cnt + 32'd1;
            end
            if (w_disc_inc && !(&r_discard_cnt)) begin
                r_discard_cnt <= r_discard_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ifid_load),
        .i_clear (w_ifid_clear),
        .i_inst  (w_ifid_inst_d),
        .i_pc4   (w_ifid_pc4_d),
        .o_inst  (ifid_inst),
        .o_pc4   (ifid_pc4),
        .o_valid (ifid_valid)
    );

    assign fetched_cnt = r_fetched_cnt;
    assign discard_cnt = r_discard_cnt;

endmodule
`default_nettype wire
